// File: rtl/forward_controller.sv
// forward_controller: hazard detection and operand-forwarding control for the
// 5-stage pipeline. It shadows the EX and MEM destination registers, drives the
// registered forwarding select word for the instruction in EX, and stalls IF/ID
// for one cycle on a load-use hazard.
// Optional build macro: FWD_STALL_CNT_EN adds a saturating stall-cycle counter
// (parameter CNT_W, port stall_count).
module forward_controller #(
  parameter int unsigned REG_AW = 5
`ifdef FWD_STALL_CNT_EN
  ,
  parameter int unsigned CNT_W  = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              flush,
  input  logic              hold,
  output logic              stall,
  output logic              ex_bubble,
  output logic [3:0]        redirection_ctrl
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_count
`endif
);

  typedef enum logic [0:0] {RUN = 1'b0, STALL = 1'b1} state_e;

  state_e state_q, state_d;

  logic [REG_AW-1:0] ex_dst_q, mem_dst_q;
  logic              ex_we_q, ex_load_q, mem_we_q;
  logic [3:0]        redir_q, redir_d;

  logic ex_rs_match, ex_rt_match, mem_rs_match, mem_rt_match;
  logic hazard;

  // Compare ID sources against the shadowed EX/MEM destinations; $0 never matches
  always_comb begin
    ex_rs_match  = id_use_rs & ex_we_q  & (ex_dst_q  == id_rs) & (id_rs != '0);
    ex_rt_match  = id_use_rt & ex_we_q  & (ex_dst_q  == id_rt) & (id_rt != '0);
    mem_rs_match = id_use_rs & mem_we_q & (mem_dst_q == id_rs) & (id_rs != '0);
    mem_rt_match = id_use_rt & mem_we_q & (mem_dst_q == id_rt) & (id_rt != '0);
    hazard       = id_valid & (ex_rs_match | ex_rt_match) & ex_load_q;
  end

  // Next forwarding select: EX result wins over MEM, load results in EX are not forwardable
  always_comb begin
    redir_d = 4'b0000;
    if (ex_rs_match & ~ex_load_q) begin
      redir_d[0] = 1'b1;
    end else if (mem_rs_match) begin
      redir_d[1] = 1'b1;
    end
    if (ex_rt_match & ~ex_load_q) begin
      redir_d[2] = 1'b1;
    end else if (mem_rt_match) begin
      redir_d[3] = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a stall lasts exactly one (non-held) cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (stall) state_d = STALL;
      STALL:   if (!hold) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // FSM outputs: flush squashes the hazard, hold freezes everything
  always_comb begin
    stall     = 1'b0;
    ex_bubble = 1'b0;
    if (!hold) begin
      stall     = hazard & ~flush & (state_q == RUN);
      ex_bubble = stall | flush;
    end
  end

  // Shadow pipeline slots and registered forwarding select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_dst_q  <= '0;
      ex_we_q   <= 1'b0;
      ex_load_q <= 1'b0;
      mem_dst_q <= '0;
      mem_we_q  <= 1'b0;
      redir_q   <= 4'b0000;
    end else if (!hold) begin
      mem_dst_q <= ex_dst_q;
      mem_we_q  <= ex_we_q;
      if (ex_bubble || !id_valid) begin
        ex_dst_q  <= '0;
        ex_we_q   <= 1'b0;
        ex_load_q <= 1'b0;
        redir_q   <= 4'b0000;
      end else begin
        ex_dst_q  <= id_dst;
        ex_we_q   <= id_reg_write;
        ex_load_q <= id_is_load;
        redir_q   <= redir_d;
      end
    end
  end

  assign redirection_ctrl = redir_q;

`ifdef FWD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_count_q;

  // Saturating count of stall cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= '0;
    end else if (stall && (stall_count_q != '1)) begin
      stall_count_q <= stall_count_q + CNT_W'(1);
    end
  end

  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_forward_controller.sv
// Directed, table-driven bench for forward_controller.
module tb_forward_controller;

  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_use_rs, id_use_rt, id_reg_write, id_is_load;
  logic [AW-1:0] id_rs, id_rt, id_dst;
  logic          flush, hold;
  logic          stall, ex_bubble;
  logic [3:0]    redirection_ctrl;
`ifdef FWD_STALL_CNT_EN
  logic [31:0]   stall_count;
`endif

  forward_controller #(.REG_AW(AW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .id_valid         (id_valid),
    .id_rs            (id_rs),
    .id_rt            (id_rt),
    .id_use_rs        (id_use_rs),
    .id_use_rt        (id_use_rt),
    .id_dst           (id_dst),
    .id_reg_write     (id_reg_write),
    .id_is_load       (id_is_load),
    .flush            (flush),
    .hold             (hold),
    .stall            (stall),
    .ex_bubble        (ex_bubble),
    .redirection_ctrl (redirection_ctrl)
`ifdef FWD_STALL_CNT_EN
    ,
    .stall_count      (stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          urs;
    logic          urt;
    logic [AW-1:0] dst;
    logic          we;
    logic          ld;
    logic          fl;
    logic          hd;
    logic          es;
    logic          eb;
    logic [3:0]    er;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_cnt = 0;

  function automatic vec_t mk(input logic v, input int rs, input int rt,
                              input logic urs, input logic urt, input int dst,
                              input logic we, input logic ld, input logic fl,
                              input logic hd, input logic es, input logic eb,
                              input logic [3:0] er);
    vec_t r;
    r.v = v; r.rs = AW'(rs); r.rt = AW'(rt); r.urs = urs; r.urt = urt;
    r.dst = AW'(dst); r.we = we; r.ld = ld; r.fl = fl; r.hd = hd;
    r.es = es; r.eb = eb; r.er = er;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    id_valid = x.v; id_rs = x.rs; id_rt = x.rt; id_use_rs = x.urs;
    id_use_rt = x.urt; id_dst = x.dst; id_reg_write = x.we;
    id_is_load = x.ld; flush = x.fl; hold = x.hd;
  endtask

  // Drive one ID cycle at the falling edge, check comb outputs, then the registered select
  task automatic run_vec(input string tag, input vec_t x);
    @(negedge clk);
    drive(x);
    #1;
    chk({tag, "_stall"}, 32'(stall), 32'(x.es));
    chk({tag, "_bubble"}, 32'(ex_bubble), 32'(x.eb));
    if (x.es) exp_cnt++;
    @(posedge clk);
    #1;
    chk({tag, "_redir"}, 32'(redirection_ctrl), 32'(x.er));
  endtask

  initial begin
    vec_t nop_v;
    nop_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0);

    // add $3,$1,$2 ; sub $5,$3,$4 -> EX forward on A
    vecs.push_back(nop_v);
    vecs.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 4'h0));
    vecs.push_back(mk(1, 3, 4, 1, 1, 5, 1, 0, 0, 0, 0, 0, 4'h1));
    // add $3 ; xor $8,$9,$10 ; or $6,$4,$3 -> MEM forward on B
    vecs.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 4'h0));
    vecs.push_back(mk(1, 9, 10, 1, 1, 8, 1, 0, 0, 0, 0, 0, 4'h0));
    vecs.push_back(mk(1, 4, 3, 1, 1, 6, 1, 0, 0, 0, 0, 0, 4'h8));
    // lw $3,0($1) ; add $4,$3,$3 -> one stall, then MEM forward on both
    vecs.push_back(mk(1, 1, 3, 1, 0, 3, 1, 1, 0, 0, 0, 0, 4'h0));
    vecs.push_back(mk(1, 3, 3, 1, 1, 4, 1, 0, 0, 0, 1, 1, 4'h0));
    vecs.push_back(mk(1, 3, 3, 1, 1, 4, 1, 0, 0, 0, 0, 0, 4'hA));
    // add $3 ; add $3 ; and $7,$3,$3 -> EX beats MEM
    vecs.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 4'h0));
    vecs.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 4'h0));
    vecs.push_back(mk(1, 3, 3, 1, 1, 7, 1, 0, 0, 0, 0, 0, 4'h5));
    // writes to $0 then a read of $0 -> no forwarding
    vecs.push_back(mk(1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 0, 0, 4'h0));
    vecs.push_back(mk(1, 5, 6, 1, 1, 0, 1, 0, 0, 0, 0, 0, 4'h0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 9, 1, 0, 0, 0, 0, 0, 4'h0));
    // lw $3 ; dependent add squashed by flush -> bubble without stall
    vecs.push_back(mk(1, 1, 3, 1, 0, 3, 1, 1, 0, 0, 0, 0, 4'h0));
    vecs.push_back(mk(1, 3, 3, 1, 1, 4, 1, 0, 1, 0, 0, 1, 4'h0));
    // add $1,$5,$6 ; lw $3,0($1) (forwarded) ; add $4,$3,$3 held 3 cycles
    vecs.push_back(mk(1, 5, 6, 1, 1, 1, 1, 0, 0, 0, 0, 0, 4'h0));
    vecs.push_back(mk(1, 1, 3, 1, 0, 3, 1, 1, 0, 0, 0, 0, 4'h1));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1, 3, 3, 1, 1, 4, 1, 0, 0, 1, 0, 0, 4'h1));
    vecs.push_back(mk(1, 3, 3, 1, 1, 4, 1, 0, 0, 0, 1, 1, 4'h0));
    vecs.push_back(mk(1, 3, 3, 1, 1, 4, 1, 0, 0, 0, 0, 0, 4'hA));

    // Reset
    drive(nop_v);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_redir", 32'(redirection_ctrl), 32'h0);
    chk("reset_stall", 32'(stall), 32'h0);
    chk("reset_bubble", 32'(ex_bubble), 32'h0);
`ifdef FWD_STALL_CNT_EN
    chk("reset_cnt", stall_count, 32'h0);
`endif
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec($sformatf("row%0d", i), vecs[i]);
`ifdef FWD_STALL_CNT_EN
    chk("table_cnt", stall_count, 32'(exp_cnt));
`endif

    // lw $3,0($4) forwarded from EX, then dependent add; reset asserted mid-stall
    run_vec("rst_lw", mk(1, 4, 3, 1, 0, 3, 1, 1, 0, 0, 0, 0, 4'h1));
    @(negedge clk);
    drive(mk(1, 3, 3, 1, 1, 5, 1, 0, 0, 0, 0, 0, 4'h0));
    #1;
    chk("rst_pre_stall", 32'(stall), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_redir", 32'(redirection_ctrl), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_bubble", 32'(ex_bubble), 32'h0);
`ifdef FWD_STALL_CNT_EN
    chk("rst_cnt", stall_count, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    // First post-reset cycle: nothing to forward, then RUN handles a new load-use once
    run_vec("post_add", mk(1, 3, 3, 1, 1, 5, 1, 0, 0, 0, 0, 0, 4'h0));
    run_vec("post_lw", mk(1, 1, 3, 1, 0, 3, 1, 1, 0, 0, 0, 0, 4'h0));
    run_vec("post_use1", mk(1, 3, 3, 1, 1, 4, 1, 0, 0, 0, 1, 1, 4'h0));
    run_vec("post_use2", mk(1, 3, 3, 1, 1, 4, 1, 0, 0, 0, 0, 0, 4'hA));
`ifdef FWD_STALL_CNT_EN
    chk("post_cnt", stall_count, 32'(exp_cnt));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
